// File: rtl/game_undo_if.sv
// game_undo_if: request/response bundle between the move engine (master) and the undo history (slave).
interface game_undo_if #(
  parameter int STATE_W = 134,
  parameter int DEPTH   = 16,
  parameter int STEP_W  = 8
);
  localparam int LVL_W = $clog2(DEPTH) + 1;
  logic               clr;
  logic               push;
  logic [STATE_W-1:0] push_state;
  logic               pop;
  logic               redo;
  logic [STEP_W-1:0]  step_limit;
  logic [STATE_W-1:0] out_state;
  logic               out_valid;
  logic [LVL_W-1:0]   level;
  logic               empty;
  logic               full;
  logic               lost;
  logic               err;
  logic [STEP_W-1:0]  step;
  logic               over_limit;
  logic               redo_avail;
  modport master (
    output clr, push, push_state, pop, redo, step_limit,
    input  out_state, out_valid, level, empty, full, lost, err, step, over_limit, redo_avail
  );
  modport slave (
    input  clr, push, push_state, pop, redo, step_limit,
    output out_state, out_valid, level, empty, full, lost, err, step, over_limit, redo_avail
  );
endinterface

// File: rtl/game_undo_stack.sv
// game_undo_stack: circular multi-level undo history of game states with an owned step counter.
// Redo support is built only when GAME_UNDO_REDO_EN is defined.
module game_undo_stack #(
  parameter int STATE_W = 134,
  parameter int DEPTH   = 16,
  parameter int STEP_W  = 8
) (
  input logic        clk,
  input logic        rst_n,
  game_undo_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  typedef enum logic [2:0] {
    A_IDLE, A_CLR, A_COLL, A_PUSH, A_POP, A_POP_ERR, A_REDO, A_REDO_ERR
  } act_t;
  act_t               w_act;
  logic [STATE_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]      r_wp, w_wp_nxt, w_rd_idx;
  logic [LW-1:0]      r_level, w_level_nxt;
  logic [STEP_W-1:0]  r_step, w_step_nxt;
  logic [STATE_W-1:0] r_out_state;
  logic               r_out_valid, r_err, r_lost, w_lost_nxt;
  logic               w_empty, w_full, w_step_max, w_redo_req, w_redo_ok;
  assign w_empty    = r_level == '0;
  assign w_full     = r_level == LW'(DEPTH);
  assign w_step_max = r_step == '1;
`ifdef GAME_UNDO_REDO_EN
  // Entries undone but not yet overwritten; a push discards them.
  logic [LW-1:0] r_redo, w_redo_nxt, w_redo_inc, w_redo_cap;
  assign w_redo_req = bus.redo;
  assign w_redo_ok  = r_redo != '0;
  assign w_redo_inc = r_redo + LW'(1);
  assign w_redo_cap = LW'(DEPTH) - w_level_nxt;
  always_comb begin
    w_redo_nxt = r_redo;
    w_redo_nxt = (w_act == A_CLR || w_act == A_PUSH) ? '0 :
                 (w_act == A_POP) ? ((w_redo_inc > w_redo_cap) ? w_redo_cap : w_redo_inc) :
                 (w_act == A_REDO) ? r_redo - LW'(1) : r_redo;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_redo <= '0;
    else        r_redo <= w_redo_nxt;
  assign bus.redo_avail = w_redo_ok;
`else
  logic w_unused_redo;
  assign w_unused_redo  = bus.redo;
  assign w_redo_req     = 1'b0;
  assign w_redo_ok      = 1'b0;
  assign bus.redo_avail = 1'b0;
`endif
  // One action per cycle: clr > push/pop collision > push > pop > redo.
  always_comb begin
    w_act = A_IDLE;
    w_act = bus.clr ? A_CLR :
            (bus.push && bus.pop) ? A_COLL :
            bus.push ? A_PUSH :
            bus.pop ? (w_empty ? A_POP_ERR : A_POP) :
            w_redo_req ? (w_redo_ok ? A_REDO : A_REDO_ERR) : A_IDLE;
  end
  always_comb begin
    w_wp_nxt    = r_wp;
    w_level_nxt = r_level;
    w_step_nxt  = r_step;
    w_lost_nxt  = r_lost;
    w_rd_idx    = r_wp;
    w_wp_nxt    = (w_act == A_CLR) ? '0 :
                  (w_act == A_PUSH || w_act == A_REDO) ? r_wp + AW'(1) :
                  (w_act == A_POP) ? r_wp - AW'(1) : r_wp;
    w_level_nxt = (w_act == A_CLR) ? '0 :
                  (w_act == A_PUSH) ? (w_full ? r_level : r_level + LW'(1)) :
                  (w_act == A_REDO) ? r_level + LW'(1) :
                  (w_act == A_POP) ? r_level - LW'(1) : r_level;
    w_step_nxt  = (w_act == A_CLR) ? '0 :
                  (w_act == A_PUSH || w_act == A_REDO) ? (w_step_max ? r_step : r_step + STEP_W'(1)) :
                  (w_act == A_POP) ? ((r_step == '0) ? r_step : r_step - STEP_W'(1)) : r_step;
    w_lost_nxt  = (w_act == A_CLR) ? 1'b0 : (w_act == A_PUSH && w_full) ? 1'b1 : r_lost;
    w_rd_idx    = (w_act == A_POP) ? r_wp - AW'(1) : r_wp;
  end
  always_ff @(posedge clk)
    if (w_act == A_PUSH) r_mem[r_wp] <= bus.push_state;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_wp        <= '0;
      r_level     <= '0;
      r_step      <= '0;
      r_lost      <= 1'b0;
      r_err       <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_state <= '0;
    end else begin
      r_wp        <= w_wp_nxt;
      r_level     <= w_level_nxt;
      r_step      <= w_step_nxt;
      r_lost      <= w_lost_nxt;
      r_err       <= w_act == A_COLL || w_act == A_POP_ERR || w_act == A_REDO_ERR;
      r_out_valid <= w_act == A_POP || w_act == A_REDO;
      if (w_act == A_POP || w_act == A_REDO) r_out_state <= r_mem[w_rd_idx];
    end
  assign bus.out_state  = r_out_state;
  assign bus.out_valid  = r_out_valid;
  assign bus.level      = r_level;
  assign bus.empty      = w_empty;
  assign bus.full       = w_full;
  assign bus.lost       = r_lost;
  assign bus.err        = r_err;
  assign bus.step       = r_step;
  assign bus.over_limit = r_step > bus.step_limit;
endmodule

// File: tb/tb_game_undo_stack.sv
// tb_game_undo_stack: directed scenarios plus randomized ops checked against a queue-based history model.
module tb_game_undo_stack;
  localparam int SW = 134;
  localparam int D  = 16;
  localparam int TW = 8;
  typedef logic [SW-1:0] st_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  game_undo_if #(.STATE_W(SW), .DEPTH(D), .STEP_W(TW)) b();
  game_undo_if #(.STATE_W(8), .DEPTH(4), .STEP_W(2)) s();
  game_undo_stack #(.STATE_W(SW), .DEPTH(D), .STEP_W(TW)) dut (.clk(clk), .rst_n(rst_n), .bus(b));
  game_undo_stack #(.STATE_W(8), .DEPTH(4), .STEP_W(2)) dut_sat (.clk(clk), .rst_n(rst_n), .bus(s));
  st_t q_hist[$];
  st_t q_redo[$];
  st_t m_out;
  bit  m_valid, m_err, m_lost;
  int  m_step;
  int  checks = 0;
  int  failures = 0;

  function automatic st_t rnd_st();
    logic [159:0] w;
    w = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    return w[SW-1:0];
  endfunction

  task automatic model_reset();
    q_hist.delete(); q_redo.delete();
    m_out = '0; m_valid = 0; m_err = 0; m_lost = 0; m_step = 0;
  endtask

  task automatic op(input bit c, input bit pu, input bit po, input bit re, input st_t st);
    b.clr = c; b.push = pu; b.pop = po; b.redo = re; b.push_state = st;
    @(posedge clk); #1;
    b.clr = 0; b.push = 0; b.pop = 0; b.redo = 0;
    m_valid = 0; m_err = 0;
    if (c) begin
      q_hist.delete(); q_redo.delete(); m_step = 0; m_lost = 0;
    end else if (pu && po) m_err = 1;
    else if (pu) begin
      if (q_hist.size() == D) begin void'(q_hist.pop_front()); m_lost = 1; end
      q_hist.push_back(st); q_redo.delete();
      m_step = (m_step == 255) ? 255 : m_step + 1;
    end else if (po) begin
      if (q_hist.size() == 0) m_err = 1;
      else begin
        m_out = q_hist.pop_back(); q_redo.push_back(m_out); m_valid = 1;
        m_step = (m_step > 0) ? m_step - 1 : 0;
      end
    end
`ifdef GAME_UNDO_REDO_EN
    else if (re) begin
      if (q_redo.size() == 0) m_err = 1;
      else begin
        m_out = q_redo.pop_back(); q_hist.push_back(m_out); m_valid = 1;
        m_step = (m_step == 255) ? 255 : m_step + 1;
      end
    end
`endif
  endtask

  task automatic test_reset();
    #2;
    checks++; if (b.out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", b.out_valid); end
    checks++; if (b.err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", b.err); end
    checks++; if (b.level !== 5'd0 || b.empty !== 1'b1) begin failures++; $display("FAIL reset_level got=%0d empty=%b exp=0/1", b.level, b.empty); end
    checks++; if (b.step !== 8'd0 || b.lost !== 1'b0) begin failures++; $display("FAIL reset_step got=%0d lost=%b exp=0/0", b.step, b.lost); end
    checks++; if (b.out_state !== st_t'(0)) begin failures++; $display("FAIL reset_out_state got=%h exp=0", b.out_state); end
    @(posedge clk); #1; rst_n = 1'b1;
    @(posedge clk); #1;
    model_reset();
  endtask

  task automatic test_pop_empty();
    op(0, 0, 1, 0, '0);
    checks++; if (b.err !== 1'b1) begin failures++; $display("FAIL pop_empty_err got=%b exp=1", b.err); end
    checks++; if (b.out_valid !== 1'b0 || b.level !== 5'd0 || b.step !== 8'd0) begin failures++; $display("FAIL pop_empty_state got valid=%b level=%0d step=%0d exp 0/0/0", b.out_valid, b.level, b.step); end
    op(0, 0, 0, 0, '0);
    checks++; if (b.err !== 1'b0) begin failures++; $display("FAIL pop_empty_err_pulse got=%b exp=0", b.err); end
  endtask

  task automatic test_lifo();
    st_t v[3];
    for (int i = 0; i < 3; i++) begin v[i] = rnd_st(); v[i][1:0] = 2'(i); op(0, 1, 0, 0, v[i]); end
    checks++; if (b.level !== 5'd3 || b.step !== 8'd3) begin failures++; $display("FAIL lifo_fill got level=%0d step=%0d exp 3/3", b.level, b.step); end
    for (int i = 0; i < 3; i++) begin
      op(0, 0, 1, 0, '0);
      checks++; if (b.out_valid !== 1'b1 || b.out_state !== v[2-i]) begin failures++; $display("FAIL lifo_pop%0d got valid=%b state=%h exp 1/%h", i, b.out_valid, b.out_state, v[2-i]); end
      checks++; if (int'(b.step) != 2 - i || int'(b.level) != 2 - i) begin failures++; $display("FAIL lifo_count%0d got step=%0d level=%0d exp %0d", i, b.step, b.level, 2 - i); end
    end
    checks++; if (b.empty !== 1'b1) begin failures++; $display("FAIL lifo_empty got=%b exp=1", b.empty); end
    op(0, 0, 0, 0, '0);
    checks++; if (b.out_valid !== 1'b0 || b.out_state !== v[0]) begin failures++; $display("FAIL lifo_hold got valid=%b state=%h exp 0/%h", b.out_valid, b.out_state, v[0]); end
  endtask

  task automatic test_overflow();
    st_t v[18];
    op(1, 0, 0, 0, '0);
    for (int i = 0; i < 18; i++) begin v[i] = rnd_st(); v[i][4:0] = 5'(i); op(0, 1, 0, 0, v[i]); end
    checks++; if (b.full !== 1'b1 || b.level !== 5'd16) begin failures++; $display("FAIL ovf_full got full=%b level=%0d exp 1/16", b.full, b.level); end
    checks++; if (b.lost !== 1'b1 || b.step !== 8'd18) begin failures++; $display("FAIL ovf_lost got lost=%b step=%0d exp 1/18", b.lost, b.step); end
    for (int i = 0; i < 16; i++) begin
      op(0, 0, 1, 0, '0);
      checks++; if (b.out_valid !== 1'b1 || b.out_state !== v[17-i]) begin failures++; $display("FAIL ovf_pop%0d got valid=%b state=%h exp 1/%h", i, b.out_valid, b.out_state, v[17-i]); end
    end
    op(0, 0, 1, 0, '0);
    checks++; if (b.err !== 1'b1 || b.out_valid !== 1'b0 || b.step !== 8'd2) begin failures++; $display("FAIL ovf_underflow got err=%b valid=%b step=%0d exp 1/0/2", b.err, b.out_valid, b.step); end
  endtask

  task automatic test_collision();
    op(0, 1, 0, 0, rnd_st());
    op(0, 1, 0, 0, rnd_st());
    op(0, 1, 1, 0, rnd_st());
    checks++; if (b.err !== 1'b1 || b.out_valid !== 1'b0) begin failures++; $display("FAIL coll_err got err=%b valid=%b exp 1/0", b.err, b.out_valid); end
    checks++; if (b.level !== 5'd2 || b.step !== 8'd4) begin failures++; $display("FAIL coll_state got level=%0d step=%0d exp 2/4", b.level, b.step); end
    op(1, 0, 0, 0, '0);
    checks++; if (b.level !== 5'd0 || b.step !== 8'd0 || b.lost !== 1'b0 || b.err !== 1'b0) begin failures++; $display("FAIL clr got level=%0d step=%0d lost=%b err=%b exp 0/0/0/0", b.level, b.step, b.lost, b.err); end
  endtask

  task automatic test_redo();
    st_t v[4];
    op(1, 0, 0, 0, '0);
    for (int i = 0; i < 4; i++) begin v[i] = rnd_st(); v[i][1:0] = 2'(i); end
    for (int i = 0; i < 3; i++) op(0, 1, 0, 0, v[i]);
    op(0, 0, 1, 0, '0);
    op(0, 0, 1, 0, '0);
    op(0, 0, 0, 1, '0);
`ifdef GAME_UNDO_REDO_EN
    checks++; if (b.out_valid !== 1'b1 || b.out_state !== v[1]) begin failures++; $display("FAIL redo_value got valid=%b state=%h exp 1/%h", b.out_valid, b.out_state, v[1]); end
    checks++; if (b.level !== 5'd2 || b.step !== 8'd2 || b.redo_avail !== 1'b1) begin failures++; $display("FAIL redo_state got level=%0d step=%0d avail=%b exp 2/2/1", b.level, b.step, b.redo_avail); end
    op(0, 1, 0, 0, v[3]);
    checks++; if (b.redo_avail !== 1'b0) begin failures++; $display("FAIL redo_discard got=%b exp=0", b.redo_avail); end
    op(0, 0, 0, 1, '0);
    checks++; if (b.err !== 1'b1 || b.out_valid !== 1'b0) begin failures++; $display("FAIL redo_err got err=%b valid=%b exp 1/0", b.err, b.out_valid); end
`else
    checks++; if (b.out_valid !== 1'b0 || b.err !== 1'b0) begin failures++; $display("FAIL redo_ignored got valid=%b err=%b exp 0/0", b.out_valid, b.err); end
    checks++; if (b.level !== 5'd1 || b.step !== 8'd1 || b.redo_avail !== 1'b0) begin failures++; $display("FAIL redo_state got level=%0d step=%0d avail=%b exp 1/1/0", b.level, b.step, b.redo_avail); end
    op(0, 1, 0, 0, v[3]);
    op(0, 0, 0, 1, '0);
    checks++; if (b.err !== 1'b0 || b.level !== 5'd2) begin failures++; $display("FAIL redo_ignored2 got err=%b level=%0d exp 0/2", b.err, b.level); end
`endif
  endtask

  task automatic test_limit();
    b.step_limit = 8'd2;
    op(1, 0, 0, 0, '0);
    for (int i = 1; i <= 3; i++) begin
      op(0, 1, 0, 0, rnd_st());
      checks++; if (b.over_limit !== (i > 2)) begin failures++; $display("FAIL limit_push%0d got=%b exp=%b", i, b.over_limit, i > 2); end
    end
    op(0, 0, 1, 0, '0);
    checks++; if (b.over_limit !== 1'b0) begin failures++; $display("FAIL limit_pop got=%b exp=0", b.over_limit); end
  endtask

  task automatic test_saturation();
    logic [7:0] last;
    for (int i = 0; i < 5; i++) begin
      last = 8'($urandom());
      s.push_state = last; s.push = 1'b1;
      @(posedge clk); #1;
    end
    s.push = 1'b0;
    checks++; if (s.step !== 2'd3 || s.full !== 1'b1 || s.lost !== 1'b1) begin failures++; $display("FAIL sat_step got step=%0d full=%b lost=%b exp 3/1/1", s.step, s.full, s.lost); end
    s.pop = 1'b1; @(posedge clk); #1; s.pop = 1'b0;
    checks++; if (s.step !== 2'd2 || s.out_state !== last || s.out_valid !== 1'b1) begin failures++; $display("FAIL sat_pop got step=%0d state=%h valid=%b exp 2/%h/1", s.step, s.out_state, s.out_valid, last); end
  endtask

  task automatic test_random();
    int r;
    for (int n = 0; n < 600; n++) begin
      b.step_limit = 8'($urandom_range(0, 20));
      r = $urandom_range(0, 99);
      if (r < 3) op(1, 0, 0, 0, '0);
      else if (r < 8) op(0, 1, 1, 0, rnd_st());
      else if (r < 48) op(0, 1, 0, 0, rnd_st());
      else if (r < 80) op(0, 0, 1, 0, '0);
      else if (r < 95) op(0, 0, 0, 1, '0);
      else op(0, 0, 0, 0, '0);
      checks++; if (b.out_valid !== m_valid || b.err !== m_err) begin failures++; $display("FAIL rnd_pulse#%0d got valid=%b err=%b exp %b/%b", n, b.out_valid, b.err, m_valid, m_err); end
      checks++; if (b.out_state !== m_out) begin failures++; $display("FAIL rnd_state#%0d got=%h exp=%h", n, b.out_state, m_out); end
      checks++; if (int'(b.level) != q_hist.size() || b.empty !== (q_hist.size() == 0) || b.full !== (q_hist.size() == D)) begin failures++; $display("FAIL rnd_level#%0d got=%0d empty=%b full=%b exp=%0d", n, b.level, b.empty, b.full, q_hist.size()); end
      checks++; if (int'(b.step) != m_step || b.lost !== m_lost) begin failures++; $display("FAIL rnd_step#%0d got step=%0d lost=%b exp %0d/%b", n, b.step, b.lost, m_step, m_lost); end
      checks++; if (b.over_limit !== (m_step > int'(b.step_limit))) begin failures++; $display("FAIL rnd_over#%0d got=%b step=%0d limit=%0d", n, b.over_limit, m_step, b.step_limit); end
`ifdef GAME_UNDO_REDO_EN
      checks++; if (b.redo_avail !== (q_redo.size() > 0)) begin failures++; $display("FAIL rnd_redo#%0d got=%b exp=%b", n, b.redo_avail, q_redo.size() > 0); end
`else
      checks++; if (b.redo_avail !== 1'b0) begin failures++; $display("FAIL rnd_redo#%0d got=%b exp=0", n, b.redo_avail); end
`endif
    end
  endtask

  task automatic test_async_reset();
    op(1, 0, 0, 0, '0);
    op(0, 1, 0, 0, rnd_st());
    op(0, 1, 1, 0, '0);
    rst_n = 1'b0; #1;
    checks++; if (b.err !== 1'b0 || b.level !== 5'd0 || b.step !== 8'd0) begin failures++; $display("FAIL arst_err got err=%b level=%0d step=%0d exp 0/0/0", b.err, b.level, b.step); end
    @(posedge clk); #1; rst_n = 1'b1; model_reset();
    op(0, 1, 0, 0, rnd_st());
    op(0, 0, 1, 0, '0);
    rst_n = 1'b0; #1;
    checks++; if (b.out_valid !== 1'b0 || b.out_state !== st_t'(0)) begin failures++; $display("FAIL arst_valid got valid=%b state=%h exp 0/0", b.out_valid, b.out_state); end
    @(posedge clk); #1; rst_n = 1'b1; model_reset();
  endtask

  initial begin
    b.clr = 0; b.push = 0; b.pop = 0; b.redo = 0; b.push_state = '0; b.step_limit = '1;
    s.clr = 0; s.push = 0; s.pop = 0; s.redo = 0; s.push_state = '0; s.step_limit = '1;
    test_reset();
    test_pop_empty();
    test_lifo();
    test_overflow();
    test_collision();
    test_redo();
    test_limit();
    test_saturation();
    b.step_limit = '1;
    op(1, 0, 0, 0, '0);
    test_random();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
